// File: rtl/stream_mux_nx1.sv
// rtl/stream_mux_nx1.sv - N-input registered stream mux with fixed/round-robin select and packet lock
module stream_mux_nx1 #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_last,
   input  logic [SELW-1:0]      sel,
   input  logic                 rr_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   output logic [SELW-1:0]      out_ch
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [SELW-1:0]  cur_q, cur_d;
   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic [SELW-1:0]  out_ch_q, out_ch_d;

   logic [SELW-1:0]  grant;
   logic             grant_ok;
   logic             load_en;
   logic             accept;
   logic             g_valid;
   logic             g_last;
   logic [WIDTH-1:0] g_data;
   int               idx;

   // Round-robin: walk from the farthest candidate back so the nearest valid one wins.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      idx      = 0;
      if (state_q == ST_LOCKED) begin
         grant    = cur_q;
         grant_ok = 1'b1;
      end else if (!rr_mode) begin
         grant    = sel;
         grant_ok = (int'(sel) < N);
      end else begin
         for (int k = N; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (in_valid[idx]) begin
               grant    = SELW'(idx);
               grant_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      g_valid  = 1'b0;
      g_last   = 1'b0;
      g_data   = '0;
      in_ready = '0;
      load_en  = !out_valid_q || out_ready;
      for (int i = 0; i < N; i++) begin
         if (SELW'(i) == grant) begin
            g_valid     = in_valid[i];
            g_last      = in_last[i];
            g_data      = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = load_en && grant_ok;
         end
      end
      accept = load_en && grant_ok && g_valid;
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = g_data;
         out_last_d  = g_last;
         out_ch_d    = grant;
         if (g_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = grant;
         end else begin
            state_d = ST_LOCKED;
            cur_d   = grant;
         end
      end else if (load_en) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         rr_ptr_q    <= SELW'(N - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb/tb_stream_mux_nx1.sv - directed and randomized bench for stream_mux_nx1 with a queue-based reference model
module tb_stream_mux_nx1;
   localparam int N    = 4;
   localparam int W    = 8;
   localparam int SELW = 2;

   logic            clk;
   logic            rst;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_last;
   logic [SELW-1:0] sel;
   logic            rr_mode;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic            out_last;
   logic [SELW-1:0] out_ch;

   stream_mux_nx1 #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .sel(sel), .rr_mode(rr_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_ch(out_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-channel producer queues: {last, data}; the front beat is what the producer presents.
   logic [8:0] q [N][$];

   int         checks = 0;
   int         passed = 0;

   // Reference model: output register contents, packet owner (-1 = none), last-served channel.
   int         m_lock;
   int         m_ptr;
   logic       m_ov;
   logic [7:0] m_od;
   logic       m_ol;
   int         m_och;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_lock = -1;
      m_ptr  = N - 1;
      m_ov   = 1'b0;
      m_od   = 8'h00;
      m_ol   = 1'b0;
      m_och  = 0;
   endtask

   function automatic int model_grant();
      int g;
      g = -1;
      if (m_lock >= 0) g = m_lock;
      else if (!rr_mode) g = (int'(sel) < N) ? int'(sel) : -1;
      else begin
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && q[(m_ptr + k) % N].size() > 0) g = (m_ptr + k) % N;
         end
      end
      return g;
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         in_valid[i]       = (q[i].size() > 0);
         in_data[i*W +: W] = 8'h00;
         in_last[i]        = 1'b0;
         if (q[i].size() > 0) begin
            in_data[i*W +: W] = q[i][0][7:0];
            in_last[i]        = q[i][0][8];
         end
      end
   endtask

   task automatic step();
      int           g;
      logic         load;
      logic         acc;
      logic [N-1:0] one;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      one     = 1;
      g       = model_grant();
      load    = !m_ov || out_ready;
      exp_rdy = (load && g >= 0) ? (one << g) : '0;
      acc     = load && g >= 0 && (q[(g < 0) ? 0 : g].size() > 0);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("out_ch", out_ch, m_och);
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else if (acc) begin
         m_ov  = 1'b1;
         m_od  = q[g][0][7:0];
         m_ol  = q[g][0][8];
         m_och = g;
         if (m_ol) begin
            m_lock = -1;
            m_ptr  = g;
         end else m_lock = g;
      end else if (load) m_ov = 1'b0;
      if (acc) void'(q[g].pop_front());
      apply();
   endtask

   task automatic clear_queues();
      for (int i = 0; i < N; i++) q[i].delete();
      apply();
   endtask

   initial begin
      int ch;
      int len;
      int guard;
      logic [7:0] t3_data [5];
      int         t3_ch   [5];
      t3_data = '{8'h11, 8'h12, 8'h13, 8'h22, 8'h20};
      t3_ch   = '{1, 1, 1, 2, 0};

      rst = 1'b1; rr_mode = 1'b0; sel = '0; out_ready = 1'b1;
      in_valid = '0; in_data = '0; in_last = '0;
      @(posedge clk);
      #1;
      model_reset();
      step();
      step();
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_ch", out_ch, 0);

      // T1: fixed select of channel 2
      rst = 1'b0; rr_mode = 1'b0; sel = 2'd2;
      q[2].push_back({1'b1, 8'hA5});
      apply();
      step();
      chk("t1_out_valid", out_valid, 1'b1);
      chk("t1_out_data", out_data, 8'hA5);
      chk("t1_out_ch", out_ch, 2);

      // T2: strict rotation from reset pointer
      rst = 1'b1;
      step();
      rst = 1'b0; rr_mode = 1'b1;
      for (int i = 0; i < N; i++) begin
         q[i].push_back({1'b1, 8'(8'h10 + i)});
         q[i].push_back({1'b1, 8'(8'h18 + i)});
      end
      apply();
      for (int s = 0; s < 5; s++) begin
         step();
         chk("t2_out_ch", out_ch, s % N);
      end

      // T3: channel 1 packet stays contiguous while 0 and 2 wait
      clear_queues();
      q[1].push_back({1'b0, 8'h11});
      q[1].push_back({1'b0, 8'h12});
      q[1].push_back({1'b1, 8'h13});
      q[0].push_back({1'b1, 8'h20});
      q[2].push_back({1'b1, 8'h22});
      apply();
      for (int s = 0; s < 5; s++) begin
         step();
         chk("t3_out_data", out_data, t3_data[s]);
         chk("t3_out_ch", out_ch, t3_ch[s]);
      end

      // T4: backpressure holds the register and blocks all inputs
      q[3].push_back({1'b0, 8'h31});
      q[3].push_back({1'b0, 8'h32});
      q[3].push_back({1'b1, 8'h33});
      apply();
      step();
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("t4_hold_data", out_data, 8'h31);
         chk("t4_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      chk("t4_next_data", out_data, 8'h32);
      step();
      chk("t4_last_data", out_data, 8'h33);
      step();
      chk("t4_drained", out_valid, 1'b0);

      // T5: sel change mid-packet is ignored until the packet ends
      rr_mode = 1'b0; sel = 2'd0;
      q[0].push_back({1'b0, 8'h40});
      q[0].push_back({1'b0, 8'h41});
      q[0].push_back({1'b1, 8'h42});
      q[3].push_back({1'b1, 8'h70});
      apply();
      step();
      sel = 2'd3;
      step();
      chk("t5_locked_ch", out_ch, 0);
      step();
      chk("t5_tail_data", out_data, 8'h42);
      step();
      chk("t5_switch_ch", out_ch, 3);
      chk("t5_switch_data", out_data, 8'h70);

      // T6: reset mid-packet clears the lock and the rotation pointer
      rr_mode = 1'b1;
      q[2].push_back({1'b0, 8'h60});
      q[2].push_back({1'b0, 8'h61});
      q[2].push_back({1'b1, 8'h62});
      apply();
      step();
      step();
      clear_queues();
      rst = 1'b1;
      step();
      chk("t6_out_valid", out_valid, 1'b0);
      rst = 1'b0;
      q[0].push_back({1'b1, 8'h50});
      q[2].push_back({1'b1, 8'h52});
      apply();
      step();
      chk("t6_first_ch", out_ch, 0);
      chk("t6_first_data", out_data, 8'h50);
      step();
      chk("t6_second_ch", out_ch, 2);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) == 0) rr_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, N - 1));
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) begin
            ch = $urandom_range(0, N - 1);
            if (q[ch].size() < 6) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) q[ch].push_back({b == len - 1, 8'($urandom)});
            end
         end
         apply();
         step();
      end

      rr_mode = 1'b1;
      out_ready = 1'b1;
      guard = 0;
      while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_ov) && guard < 200) begin
         step();
         guard++;
      end
      chk("drain_timeout", (guard < 200), 1'b1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
